// File: rtl/writeback_stage_if.sv
// Write-back stage bundle: M-side inputs, pipeline control, W-side outputs.
// Ports: master drives M/control and observes W; slave is the W stage.
// Optional WB_PERF_CNT_EN adds retired_cnt/bubble_cnt.
interface writeback_stage_if #(
    parameter int DW    = 64,
    parameter int CNT_W = 32
);
    logic          W_stall;
    logic          W_bubble;
    logic [2:0]    m_stat;
    logic [3:0]    M_icode;
    logic [DW-1:0] M_valE;
    logic [DW-1:0] m_valM;
    logic [3:0]    M_dstE;
    logic [3:0]    M_dstM;
    logic [2:0]    W_stat;
    logic [3:0]    W_icode;
    logic [DW-1:0] W_valE;
    logic [DW-1:0] W_valM;
    logic [3:0]    W_dstE;
    logic [3:0]    W_dstM;
    logic [2:0]    Stat;
    logic          halted;
    logic          retire;
`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] bubble_cnt;
`endif

    modport master (
        output W_stall, W_bubble, m_stat, M_icode,
        output M_valE, m_valM, M_dstE, M_dstM,
        input  W_stat, W_icode, W_valE, W_valM,
        input  W_dstE, W_dstM, Stat, halted, retire
`ifdef WB_PERF_CNT_EN
        , input retired_cnt, bubble_cnt
`endif
    );

    modport slave (
        input  W_stall, W_bubble, m_stat, M_icode,
        input  M_valE, m_valM, M_dstE, M_dstM,
        output W_stat, W_icode, W_valE, W_valM,
        output W_dstE, W_dstM, Stat, halted, retire
`ifdef WB_PERF_CNT_EN
        , output retired_cnt, bubble_cnt
`endif
    );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: M->W register, gated RF write port, sticky stop.
// Ports: clk, rst_n (async low), wb (slave modport of writeback_stage_if).
// Optional WB_PERF_CNT_EN: saturating retired_cnt / bubble_cnt outputs.
module writeback_stage #(
    parameter int DW    = 64,
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    writeback_stage_if.slave wb
);
    localparam logic [2:0] S_BUB  = 3'd0;
    localparam logic [2:0] S_AOK  = 3'd1;
    localparam logic [2:0] S_HLT  = 3'd2;
    localparam logic [2:0] S_ADR  = 3'd3;
    localparam logic [2:0] S_INS  = 3'd4;
    localparam logic [3:0] R_NONE = 4'hF;
    localparam logic [3:0] I_NOP  = 4'h1;

    typedef enum logic { RUN, STOP } state_e;

    typedef struct packed {
        logic [2:0]    stat;
        logic [3:0]    icode;
        logic [DW-1:0] valE;
        logic [DW-1:0] valM;
        logic [3:0]    dstE;
        logic [3:0]    dstM;
    } w_reg_t;

    w_reg_t w_q, w_d;
    state_e state_q, state_d;
    logic   fresh_q, fresh_d;
    logic   exc;
    logic   freeze;
    logic   load_bub;
    logic   retire;

    assign exc = (w_q.stat == S_HLT) || (w_q.stat == S_ADR) ||
                 (w_q.stat == S_INS);
    // The faulting instruction must stay in W, so the register
    // already freezes on the edge that moves RUN -> STOP.
    assign freeze = (state_q == STOP) || exc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == RUN && exc) begin
            state_d = STOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q.stat  <= S_BUB;
            w_q.icode <= I_NOP;
            w_q.valE  <= '0;
            w_q.valM  <= '0;
            w_q.dstE  <= R_NONE;
            w_q.dstM  <= R_NONE;
            fresh_q   <= 1'b0;
        end else begin
            w_q     <= w_d;
            fresh_q <= fresh_d;
        end
    end

    always_comb begin
        w_d      = w_q;
        fresh_d  = 1'b0;
        load_bub = 1'b0;
        priority case (1'b1)
            freeze: begin
            end
            wb.W_stall: begin
            end
            wb.W_bubble: begin
                w_d.stat  = S_BUB;
                w_d.icode = I_NOP;
                w_d.dstE  = R_NONE;
                w_d.dstM  = R_NONE;
                load_bub  = 1'b1;
            end
            default: begin
                w_d.stat  = wb.m_stat;
                w_d.icode = wb.M_icode;
                w_d.valE  = wb.M_valE;
                w_d.valM  = wb.m_valM;
                w_d.dstE  = wb.M_dstE;
                w_d.dstM  = wb.M_dstM;
                fresh_d   = (wb.m_stat != S_BUB);
                load_bub  = (wb.m_stat == S_BUB);
            end
        endcase
    end

    assign retire = fresh_q && (w_q.stat == S_AOK) && (state_q == RUN);

    assign wb.W_stat  = w_q.stat;
    assign wb.W_icode = w_q.icode;
    assign wb.W_valE  = w_q.valE;
    assign wb.W_valM  = w_q.valM;
    assign wb.W_dstE  = (w_q.stat == S_AOK) ? w_q.dstE : R_NONE;
    assign wb.W_dstM  = (w_q.stat == S_AOK) ? w_q.dstM : R_NONE;
    assign wb.Stat    = (w_q.stat == S_BUB) ? S_AOK : w_q.stat;
    assign wb.halted  = (state_q == STOP);
    assign wb.retire  = retire;

`ifdef WB_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] ret_cnt_q;
    logic [CNT_W-1:0] bub_cnt_q;

    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ret_cnt_q <= '0;
            bub_cnt_q <= '0;
        end else begin
            if (retire && !(&ret_cnt_q)) begin
                ret_cnt_q <= ret_cnt_q + CNT_ONE;
            end
            if (load_bub && !(&bub_cnt_q)) begin
                bub_cnt_q <= bub_cnt_q + CNT_ONE;
            end
        end
    end

    assign wb.retired_cnt = ret_cnt_q;
    assign wb.bubble_cnt  = bub_cnt_q;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Randomized + directed bench for writeback_stage with an in-bench model.
// Model tracks W contents, stop flag and counters from the stage's rules.
module tb_writeback_stage;
    localparam int DW    = 64;
    localparam int CNT_W = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    writeback_stage_if #(.DW(DW), .CNT_W(CNT_W)) wb ();

    writeback_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [2:0]    ms;
    logic [3:0]    mi;
    logic [DW-1:0] mvE, mvM;
    logic [3:0]    mdE, mdM;
    logic          mstop, mfresh;
    logic [CNT_W-1:0] mrc, mbc;
    logic          exp_ret;

    function automatic bit is_fault(logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    assign exp_ret = mfresh && ms == 3'd1 && !mstop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms <= 3'd0; mi <= 4'h1; mvE <= '0; mvM <= '0;
            mdE <= 4'hF; mdM <= 4'hF;
            mstop <= 1'b0; mfresh <= 1'b0;
            mrc <= '0; mbc <= '0;
        end else begin
            mfresh <= 1'b0;
            if (is_fault(ms)) mstop <= 1'b1;
            if (exp_ret && mrc != {CNT_W{1'b1}}) mrc <= mrc + 1'b1;
            if (!mstop && !is_fault(ms) && !wb.W_stall) begin
                if (wb.W_bubble) begin
                    ms <= 3'd0; mi <= 4'h1; mdE <= 4'hF; mdM <= 4'hF;
                    if (mbc != {CNT_W{1'b1}}) mbc <= mbc + 1'b1;
                end else begin
                    ms <= wb.m_stat; mi <= wb.M_icode;
                    mvE <= wb.M_valE; mvM <= wb.m_valM;
                    mdE <= wb.M_dstE; mdM <= wb.M_dstM;
                    mfresh <= (wb.m_stat != 3'd0);
                    if (wb.m_stat == 3'd0 && mbc != {CNT_W{1'b1}})
                        mbc <= mbc + 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, req, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("W_stat", 64'(wb.W_stat), 64'(ms));
            chk("W_icode", 64'(wb.W_icode), 64'(mi));
            chk("W_valE", wb.W_valE, mvE);
            chk("W_valM", wb.W_valM, mvM);
            chk("W_dstE", 64'(wb.W_dstE), 64'(ms == 3'd1 ? mdE : 4'hF));
            chk("W_dstM", 64'(wb.W_dstM), 64'(ms == 3'd1 ? mdM : 4'hF));
            chk("Stat", 64'(wb.Stat), 64'(ms == 3'd0 ? 3'd1 : ms));
            chk("halted", 64'(wb.halted), 64'(mstop));
            chk("retire", 64'(wb.retire), 64'(exp_ret));
`ifdef WB_PERF_CNT_EN
            chk("retired_cnt", 64'(wb.retired_cnt), 64'(mrc));
            chk("bubble_cnt", 64'(wb.bubble_cnt), 64'(mbc));
`endif
        end
    end

    task automatic drive(input logic [2:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic stl, input logic bub);
        wb.m_stat = st; wb.M_icode = ic;
        wb.M_valE = ve; wb.m_valM = vm;
        wb.M_dstE = de; wb.M_dstM = dm;
        wb.W_stall = stl; wb.W_bubble = bub;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle reset with an immediate check of the reset values
    task automatic do_reset(input logic hold_stall);
        @(negedge clk);
        #2;
        drive(3'd1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, hold_stall, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_icode", 64'(wb.W_icode), 64'h1);
        chk("rst_dstE", 64'(wb.W_dstE), 64'hF);
        chk("rst_dstM", 64'(wb.W_dstM), 64'hF);
        chk("rst_Stat", 64'(wb.Stat), 64'h1);
        chk("rst_halted", 64'(wb.halted), 64'h0);
        chk("rst_retire", 64'(wb.retire), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(3'd0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // Capture, then stall for 3 cycles
        drive(3'd1, 4'h3, 64'h2A, 64'h0, 4'h2, 4'hF, 1'b0, 1'b0);
        next_cyc();
        drive(3'd1, 4'h6, 64'h55, 64'h1, 4'h4, 4'h7, 1'b1, 1'b0);
        @(negedge clk);
        chk("cap_dstE", 64'(wb.W_dstE), 64'h2);
        chk("cap_valE", wb.W_valE, 64'h2A);
        chk("cap_retire", 64'(wb.retire), 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stl_valE", wb.W_valE, 64'h2A);
            chk("stl_dstE", 64'(wb.W_dstE), 64'h2);
            chk("stl_retire", 64'(wb.retire), 64'h0);
        end
        next_cyc();

        // Halt is sticky and ignores later AOK inputs
        drive(3'd2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF, 1'b0, 1'b0);
        next_cyc();
        drive(3'd1, 4'h3, 64'h11, 64'h0, 4'h1, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        chk("hlt_Stat", 64'(wb.Stat), 64'h2);
        chk("hlt_halted0", 64'(wb.halted), 64'h0);
        repeat (3) begin
            @(negedge clk);
            chk("hlt_Stat_hold", 64'(wb.Stat), 64'h2);
            chk("hlt_halted", 64'(wb.halted), 64'h1);
        end
        do_reset(1'b0);

        // Address fault on mrmovq never writes the RF
        drive(3'd3, 4'h5, 64'h0, 64'hFF, 4'hF, 4'h5, 1'b0, 1'b0);
        next_cyc();
        drive(3'd1, 4'h3, 64'h9, 64'h0, 4'h3, 4'hF, 1'b0, 1'b0);
        @(negedge clk);
        chk("adr_dstM", 64'(wb.W_dstM), 64'hF);
        chk("adr_dstE", 64'(wb.W_dstE), 64'hF);
        chk("adr_Stat", 64'(wb.Stat), 64'h3);
        chk("adr_retire", 64'(wb.retire), 64'h0);
        @(negedge clk);
        chk("adr_halted", 64'(wb.halted), 64'h1);

        // Bubble: release reset under stall so nothing loads first
        do_reset(1'b1);
        drive(3'd1, 4'h3, 64'h7, 64'h0, 4'h2, 4'hF, 1'b0, 1'b1);
        next_cyc();
        drive(3'd1, 4'h3, 64'h7, 64'h0, 4'h2, 4'hF, 1'b1, 1'b0);
        @(negedge clk);
        chk("bub_Stat", 64'(wb.Stat), 64'h1);
        chk("bub_retire", 64'(wb.retire), 64'h0);
`ifdef WB_PERF_CNT_EN
        chk("bub_cnt", 64'(wb.bubble_cnt), 64'h1);
        // Nine retirements saturate a 3-bit counter at 7
        next_cyc();
        for (int i = 0; i < 9; i++) begin
            drive(3'd1, 4'h3, 64'(i), 64'h0, 4'h2, 4'hF, 1'b0, 1'b0);
            next_cyc();
        end
        drive(3'd1, 4'h3, 64'h0, 64'h0, 4'h2, 4'hF, 1'b1, 1'b0);
        repeat (2) next_cyc();
        chk("ret_sat", 64'(wb.retired_cnt), 64'h7);
`endif

        // Randomized traffic
        do_reset(1'b0);
        for (int n = 0; n < 1500; n++) begin
            logic [2:0] st;
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 75)      st = 3'd1;
            else if (r < 95) st = 3'd0;
            else             st = 3'($urandom_range(2, 4));
            drive(st, 4'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, 4'($urandom), 4'($urandom),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 15));
            next_cyc();
            if (mstop && $urandom_range(0, 3) == 0) do_reset(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Write-back end of the Y86-64 pipeline: M→W pipeline register plus register-file write-port drive logic.
- Produces W_dstE/W_valE/W_dstM/W_valM, which feed both the register-file write port and the decode-stage forwarding network.
- Owns architectural program status (Stat) and a sticky halt/fault state machine that freezes retirement after the first non-AOK instruction.

Parameters:
- DW, 64, data width of valE/valM
- CNT_W, 32, width of optional performance counters

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- W_stall  in  1  stall from pipeline control; hold W register
- W_bubble  in  1  bubble from pipeline control; load nop/bubble
- m_stat  in  3  status from memory stage (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS)
- M_icode  in  4  icode in memory stage
- M_valE  in  DW  ALU result
- m_valM  in  DW  memory read data
- M_dstE  in  4  E destination register (F = none)
- M_dstM  in  4  M destination register (F = none)
- W_stat  out  3  registered status
- W_icode  out  4  registered icode
- W_valE  out  DW  register-file E write data
- W_valM  out  DW  register-file M write data
- W_dstE  out  4  gated register-file E write address
- W_dstM  out  4  gated register-file M write address
- Stat  out  3  architectural status
- halted  out  1  sticky stop indicator
- retire  out  1  one-cycle pulse per retired instruction

Behaviour:
- Reset (async, rst_n low):
  - Registered stat = BUB (0); W_icode = 4'h1; internal dstE/dstM = F; valE/valM = 0.
  - State = RUN; halted = 0; retire = 0; Stat = AOK.
- W register update, each rising clk, priority high→low:
  - state STOP → hold all fields.
  - W_stall → hold.
  - W_bubble → icode=1, stat=BUB, dstE=dstM=F, valE/valM unchanged.
  - else → capture m_stat, M_icode, M_valE, m_valM, M_dstE, M_dstM.
- W_stall and W_bubble both high: stall wins.
- Latency: M inputs appear on W outputs 1 cycle after capture edge.
- Write gating (combinational): W_dstE/W_dstM = registered value only when registered stat == AOK, else F. Faulting or halting instructions never write registers.
- Stat = AOK when registered stat == BUB, else registered stat.
- State machine:
  - RUN → STOP on the rising edge where registered stat ∈ {HLT, ADR, INS} and state == RUN.
  - STOP is sticky until reset; halted = (state == STOP).
  - W contents freeze, so Stat stays at the faulting code.
- Retire:
  - Internal `fresh` bit: set on a capture edge with m_stat != BUB; cleared on any other edge, including stall, bubble, and STOP.
  - retire = fresh & registered stat == AOK & state == RUN.
  - A stalled instruction retires exactly once.
- Widths: no arithmetic on data paths; values pass through unmodified.
- Reset asserted mid-STOP or mid-stall: immediate return to reset values, independent of clk.

Optional Feature:
- Macro WB_PERF_CNT_EN.
- Defined:
  - Adds outputs retired_cnt [CNT_W-1:0] and bubble_cnt [CNT_W-1:0], both reset to 0.
  - retired_cnt increments on each cycle retire = 1.
  - bubble_cnt increments on each edge that loads a bubble (W_bubble, or captured m_stat == BUB) while in RUN.
  - Both counters saturate at all-ones and never wrap.
- Undefined: ports and counter logic absent; all other behaviour identical.

Test Plan:
- Reset: assert rst_n=0 mid-clock → W_icode=1, W_dstE=W_dstM=F, Stat=1, halted=0, retire=0, all without a clk edge.
- Capture: irmovq with m_stat=1, M_icode=3, M_dstE=2, M_valE=0x2A → next cycle W_dstE=2, W_valE=0x2A, retire=1 for exactly one cycle.
- Stall: same as capture, then W_stall=1 for 3 cycles with new M inputs → W outputs unchanged, retire high only in the first cycle.
- Halt: m_stat=2, M_icode=0 captured → Stat=2, halted=1 from the following edge. Later AOK M inputs are ignored; Stat stays 2 until reset.
- Fault gating: mrmovq with m_stat=3, M_dstM=5, m_valM=0xFF → W_dstM=F, W_dstE=F, Stat=3, retire=0, halted=1.
- Bubble and counters (WB_PERF_CNT_EN):
  - W_bubble=1 → Stat=1, retire=0, bubble_cnt +1.
  - Preload retired_cnt to 2^CNT_W−2, retire 3 instructions → retired_cnt saturates at all-ones.
